// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - FP issue control: decode, scoreboard, dispatch, writeback arbitration
// Optional div/sqrt path enabled by defining FPU_DIVSQRT_EN.
module fpu_issue_ctrl #(
  parameter int PIPE_LAT = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic [2:0]  frm,
  output logic        pipe_start,
  output logic [6:0]  pipe_opcode,
  output logic [4:0]  pipe_funct5,
  output logic [2:0]  pipe_rm,
  output logic        ds_start,
  output logic        ds_sqrt,
  output logic [2:0]  ds_rm,
  input  logic        ds_done,
  output logic        ds_ack,
  output logic        wb_en,
  output logic        wb_sel,
  output logic [4:0]  wb_rd,
  output logic        wb_int,
  output logic        illegal,
  output logic        busy
);

  localparam logic [6:0] OP_FOP    = 7'b1010011;
  localparam logic [6:0] OP_FMADD  = 7'b1000011;
  localparam logic [6:0] OP_FMSUB  = 7'b1000111;
  localparam logic [6:0] OP_FNMSUB = 7'b1001011;
  localparam logic [6:0] OP_FNMADD = 7'b1001111;
  localparam logic [4:0] F5_FADD    = 5'b00000;
  localparam logic [4:0] F5_FSUB    = 5'b00001;
  localparam logic [4:0] F5_FMUL    = 5'b00010;
  localparam logic [4:0] F5_FSGNJ   = 5'b00100;
  localparam logic [4:0] F5_FMINMAX = 5'b00101;
  localparam logic [4:0] F5_FCOMP   = 5'b10100;
  localparam logic [4:0] F5_FCLASS  = 5'b11100;
  localparam logic [1:0] FMT_HALF   = 2'b10;
  localparam logic [2:0] RM_DYN     = 3'b111;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2, rs3, funct5;
  logic [2:0] rm_raw, rm_res;
  logic [1:0] fmt;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rm_raw = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign fmt    = instr[26:25];
  assign rs3    = instr[31:27];
  assign funct5 = instr[31:27];

  logic is_pipe, is_int, arith, uses_rs2, uses_rs3, is_unit, legal, hazard;
  logic accept, issue_pipe, issue_fp;
  logic [31:0] sb, sb_d;
  logic [4:0] pipe_rd_q, ds_rd_q;
  logic pipe_int_q, pipe_wb, ds_wb, ds_active;
  logic [PIPE_LAT-1:0]      sr_valid, sr_int;
  logic [PIPE_LAT-1:0][4:0] sr_rd;

`ifdef FPU_DIVSQRT_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_WB} ds_state_t;
  ds_state_t state_q, state_d;
  logic is_ds, is_sqrt, issue_ds;
  localparam logic [4:0] F5_FDIV  = 5'b00011;
  localparam logic [4:0] F5_FSQRT = 5'b01011;
`endif

  always_comb begin
    is_pipe  = 1'b0;
    is_int   = 1'b0;
    arith    = 1'b0;
    uses_rs2 = 1'b1;
    uses_rs3 = 1'b0;
`ifdef FPU_DIVSQRT_EN
    is_ds    = 1'b0;
    is_sqrt  = 1'b0;
`endif
    if (opcode == OP_FOP) begin
      case (funct5)
        F5_FADD, F5_FSUB, F5_FMUL: begin is_pipe = 1'b1; arith = 1'b1; end
        F5_FSGNJ, F5_FMINMAX:      is_pipe = 1'b1;
        F5_FCOMP:                  begin is_pipe = 1'b1; is_int = 1'b1; end
        F5_FCLASS:                 begin is_pipe = 1'b1; is_int = 1'b1; uses_rs2 = 1'b0; end
`ifdef FPU_DIVSQRT_EN
        F5_FDIV:                   begin is_ds = 1'b1; arith = 1'b1; end
        F5_FSQRT:                  begin is_ds = 1'b1; is_sqrt = 1'b1; arith = 1'b1; uses_rs2 = 1'b0; end
`endif
        default: ;
      endcase
    end else if (opcode == OP_FMADD || opcode == OP_FMSUB ||
                 opcode == OP_FNMSUB || opcode == OP_FNMADD) begin
      is_pipe  = 1'b1;
      arith    = 1'b1;
      uses_rs3 = 1'b1;
    end
  end

  // Only arithmetic ops interpret rm as a rounding mode; others carry a sub-function.
  assign rm_res = (arith && rm_raw == RM_DYN) ? frm : rm_raw;
`ifdef FPU_DIVSQRT_EN
  assign is_unit = is_pipe | is_ds;
`else
  assign is_unit = is_pipe;
`endif
  assign legal = is_unit && (fmt == FMT_HALF) && !(arith && rm_res > 3'd4);

  // Integer-destination ops do not own an FP register, so rd is not a WAW hazard for them.
  always_comb begin
    hazard = sb[rs1] | (uses_rs2 & sb[rs2]) | (uses_rs3 & sb[rs3]) | (!is_int & sb[rd]);
`ifdef FPU_DIVSQRT_EN
    if ((is_ds && state_q != S_IDLE) || (is_pipe && state_q == S_WAIT_WB))
      hazard = 1'b1;
`endif
  end

  assign instr_ready = nRST & (!legal | !hazard);
  assign accept      = instr_valid & instr_ready;
  assign issue_pipe  = accept & legal & is_pipe;
`ifdef FPU_DIVSQRT_EN
  assign issue_ds    = accept & legal & is_ds;
  assign issue_fp    = (issue_pipe & !is_int) | issue_ds;
`else
  assign issue_fp    = issue_pipe & !is_int;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pipe_start  <= 1'b0;
      pipe_opcode <= '0;
      pipe_funct5 <= '0;
      pipe_rm     <= '0;
      pipe_rd_q   <= '0;
      pipe_int_q  <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      pipe_start <= issue_pipe;
      illegal    <= accept & !legal;
      if (issue_pipe) begin
        pipe_opcode <= opcode;
        pipe_funct5 <= funct5;
        pipe_rm     <= rm_res;
        pipe_rd_q   <= rd;
        pipe_int_q  <= is_int;
      end
    end
  end

  // The dispatch register is stage zero, so PIPE_LAT shift stages land on the result cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sr_valid <= '0;
      sr_int   <= '0;
      sr_rd    <= '0;
    end else begin
      sr_valid[0] <= pipe_start;
      sr_int[0]   <= pipe_int_q;
      sr_rd[0]    <= pipe_rd_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        sr_valid[i] <= sr_valid[i-1];
        sr_int[i]   <= sr_int[i-1];
        sr_rd[i]    <= sr_rd[i-1];
      end
    end
  end

`ifdef FPU_DIVSQRT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      ds_start <= 1'b0;
      ds_sqrt  <= 1'b0;
      ds_rm    <= '0;
      ds_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      ds_start <= issue_ds;
      if (issue_ds) begin
        ds_sqrt <= is_sqrt;
        ds_rm   <= rm_res;
        ds_rd_q <= rd;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ds_wb   = 1'b0;
    case (state_q)
      S_IDLE:    if (issue_ds) state_d = S_RUN;
      S_RUN:     if (ds_done) state_d = S_WAIT_WB;
      S_WAIT_WB: begin
        ds_wb = !pipe_wb;
        if (!pipe_wb) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  assign ds_active = (state_q != S_IDLE);
`else
  logic unused_ds_done;
  assign unused_ds_done = ds_done;
  assign ds_start  = 1'b0;
  assign ds_sqrt   = 1'b0;
  assign ds_rm     = '0;
  assign ds_rd_q   = '0;
  assign ds_wb     = 1'b0;
  assign ds_active = 1'b0;
`endif

  assign pipe_wb = sr_valid[PIPE_LAT-1];
  assign wb_en   = pipe_wb | ds_wb;
  assign wb_sel  = ds_wb;
  assign wb_rd   = ds_wb ? ds_rd_q : sr_rd[PIPE_LAT-1];
  assign wb_int  = pipe_wb & sr_int[PIPE_LAT-1];
  assign ds_ack  = ds_wb;

  always_comb begin
    sb_d = sb;
    if (wb_en && !wb_int) sb_d[wb_rd] = 1'b0;
    if (issue_fp) sb_d[rd] = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) sb <= '0;
    else       sb <= sb_d;
  end

  assign busy = (|sb) | pipe_start | (|sr_valid) | ds_active;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - self-checking bench for fpu_issue_ctrl (honours FPU_DIVSQRT_EN)
module tb_fpu_issue_ctrl;
  localparam int LAT = 3;

  logic        CLK;
  logic        nRST;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [2:0]  frm;
  logic        pipe_start;
  logic [6:0]  pipe_opcode;
  logic [4:0]  pipe_funct5;
  logic [2:0]  pipe_rm;
  logic        ds_start, ds_sqrt, ds_done, ds_ack;
  logic [2:0]  ds_rm;
  logic        wb_en, wb_sel, wb_int, illegal, busy;
  logic [4:0]  wb_rd;

  fpu_issue_ctrl #(.PIPE_LAT(LAT)) dut (
    .CLK(CLK), .nRST(nRST), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .frm(frm), .pipe_start(pipe_start),
    .pipe_opcode(pipe_opcode), .pipe_funct5(pipe_funct5), .pipe_rm(pipe_rm),
    .ds_start(ds_start), .ds_sqrt(ds_sqrt), .ds_rm(ds_rm), .ds_done(ds_done),
    .ds_ack(ds_ack), .wb_en(wb_en), .wb_sel(wb_sel), .wb_rd(wb_rd),
    .wb_int(wb_int), .illegal(illegal), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fop(input logic [4:0] f5, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] rm, input logic [4:0] rd);
    return {f5, 2'b10, rs2, rs1, rm, rd, 7'b1010011};
  endfunction

  function automatic logic [31:0] fma(input logic [6:0] op, input logic [4:0] rs3,
      input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] rm, input logic [4:0] rd);
    return {rs3, 2'b10, rs2, rs1, rm, rd, op};
  endfunction

  // kind: 0 illegal, 1 pipelined, 2 div, 3 sqrt; nsrc = FP source operands read
  function automatic void m_decode(input logic [31:0] w, input logic [2:0] f, output int kind,
      output bit intd, output logic [2:0] rm, output int nsrc);
    bit arith = 0;
    kind = 0; intd = 0; nsrc = 2; rm = w[14:12];
    if (w[6:0] == 7'b1010011) begin
      case (int'(w[31:27]))
        0, 1, 2: begin kind = 1; arith = 1; end
        4, 5:    kind = 1;
        20:      begin kind = 1; intd = 1; end
        28:      begin kind = 1; intd = 1; nsrc = 1; end
        3:       begin kind = 2; arith = 1; end
        11:      begin kind = 3; arith = 1; nsrc = 1; end
        default: kind = 0;
      endcase
    end else if (w[6:0] == 7'b1000011 || w[6:0] == 7'b1000111 ||
                 w[6:0] == 7'b1001011 || w[6:0] == 7'b1001111) begin
      kind = 1; arith = 1; nsrc = 3;
    end
    if (w[26:25] != 2'b10) kind = 0;
    if (arith && rm == 3'd7) rm = f;
    if (arith && rm >= 3'd5) kind = 0;
`ifndef FPU_DIVSQRT_EN
    if (kind >= 2) kind = 0;
`endif
  endfunction

  // Model: expected events keyed by absolute cycle, plus FP busy set and div phase.
  logic [14:0] ps_at [int];
  logic [5:0]  pwb_at [int];
  logic [3:0]  ds_at [int];
  bit          ill_at [int];
  bit [31:0]   m_busy;
  int          m_ds;
  logic [4:0]  m_ds_rd;
  int          mc = 0;

  always @(negedge CLK) begin : cmp
    int kind, nsrc;
    bit intd, exp_ready, exp_wb, exp_dswb, any_busy;
    logic [2:0] rm;
    logic [4:0] r1, r2, r3, rdd;
    logic [5:0] pw;
    if (!nRST) begin
      chk("reset_outputs", {instr_ready, pipe_start, pipe_opcode, pipe_funct5, pipe_rm,
          ds_start, ds_sqrt, ds_rm, ds_ack, wb_en, wb_sel, wb_rd, wb_int, illegal, busy}, 64'd0);
      ps_at.delete(); pwb_at.delete(); ds_at.delete(); ill_at.delete();
      m_busy = '0; m_ds = 0;
    end else begin
      m_decode(instr, frm, kind, intd, rm, nsrc);
      r1 = instr[19:15]; r2 = instr[24:20]; r3 = instr[31:27]; rdd = instr[11:7];
      exp_ready = 1;
      if (kind != 0)
        exp_ready = !(m_busy[r1] || (nsrc >= 2 && m_busy[r2]) || (nsrc == 3 && m_busy[r3]) ||
                      (!intd && m_busy[rdd]) || (kind >= 2 && m_ds != 0) || (kind == 1 && m_ds == 2));
      chk("instr_ready", instr_ready, exp_ready);
      chk("pipe_start", pipe_start, ps_at.exists(mc));
      if (ps_at.exists(mc)) chk("pipe_fields", {pipe_opcode, pipe_funct5, pipe_rm}, ps_at[mc]);
      chk("ds_start", ds_start, ds_at.exists(mc));
      if (ds_at.exists(mc)) chk("ds_fields", {ds_sqrt, ds_rm}, ds_at[mc]);
      chk("illegal", illegal, ill_at.exists(mc));
      exp_wb = pwb_at.exists(mc);
      exp_dswb = !exp_wb && m_ds == 2;
      chk("wb_en", wb_en, exp_wb || exp_dswb);
      chk("ds_ack", ds_ack, exp_dswb);
      if (exp_wb) chk("wb_pipe_fields", {wb_sel, wb_rd, wb_int}, {1'b0, pwb_at[mc][4:0], pwb_at[mc][5]});
      if (exp_dswb) chk("wb_ds_fields", {wb_sel, wb_rd, wb_int}, {1'b1, m_ds_rd, 1'b0});
      any_busy = (m_busy != 0) || (m_ds != 0);
      foreach (pwb_at[k]) if (k >= mc && k - LAT <= mc) any_busy = 1;
      chk("busy", busy, any_busy);
      if (exp_wb) begin
        pw = pwb_at[mc];
        if (!pw[5]) m_busy[pw[4:0]] = 1'b0;
      end
      if (exp_dswb) begin
        m_busy[m_ds_rd] = 1'b0;
        m_ds = 0;
      end else if (m_ds == 1 && ds_done) m_ds = 2;
      if (instr_valid && exp_ready) begin
        if (kind == 0) ill_at[mc+1] = 1;
        else if (kind == 1) begin
          ps_at[mc+1] = {instr[6:0], instr[31:27], rm};
          pwb_at[mc+1+LAT] = {intd, rdd};
          if (!intd) m_busy[rdd] = 1'b1;
        end else begin
          ds_at[mc+1] = {kind == 3, rm};
          m_ds = 1; m_ds_rd = rdd;
          m_busy[rdd] = 1'b1;
        end
      end
    end
    mc++;
  end

  task automatic issue(input logic [31:0] w, output int acc);
    acc = -1;
    instr = w; instr_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (instr_ready) acc = cyc;
      @(posedge CLK); #1;
      if (acc >= 0) break;
    end
    instr_valid = 1'b0;
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL accept_timeout: instr %0h not accepted within 100 cycles", w);
    end
  endtask

`ifdef FPU_DIVSQRT_EN
  task automatic ds_complete(input int dly);
    bit hit = 0;
    repeat (dly) @(posedge CLK);
    #1 ds_done = 1'b1;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(negedge CLK);
      if (ds_ack) hit = 1;
      @(posedge CLK); #1;
    end
    ds_done = 1'b0;
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL ds_ack_timeout: got no ack expected ack within 50 cycles");
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int a, b;
    logic [31:0] w;
    logic [31:0] ill_q[$];
    nRST = 1'b0; instr_valid = 1'b1; instr = fop(5'd0, 5'd2, 5'd1, 3'd0, 5'd3);
    ds_done = 1'b0; frm = 3'd0;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1; instr_valid = 1'b0;
    @(negedge CLK);
    chk("busy_after_reset", busy, 0);

    // FADD.H f3,f1,f2 RNE: start next cycle, writeback three cycles later
    issue(fop(5'd0, 5'd2, 5'd1, 3'd0, 5'd3), a);
    @(negedge CLK);
    chk("fadd_start", {pipe_start, pipe_funct5, pipe_rm}, 9'b1_00000_000);
    repeat (3) @(negedge CLK);
    chk("fadd_wb", {wb_en, wb_sel, wb_rd}, 7'b1_0_00011);
    chk("fadd_busy_wb", busy, 1);

    issue(fop(5'd2, 5'd2, 5'd1, 3'd0, 5'd4), a);
    issue(fop(5'd0, 5'd1, 5'd4, 3'd0, 5'd5), b);
    chk("raw_stall", b - a, 5);

    issue(fop(5'd1, 5'd2, 5'd1, 3'd0, 5'd16), a);
    issue(fop(5'd0, 5'd2, 5'd1, 3'd0, 5'd17), b);
    chk("b2b_1", b - a, 1);
    issue(fop(5'd2, 5'd2, 5'd1, 3'd0, 5'd18), a);
    chk("b2b_2", a - b, 1);

    issue(fop(5'd0, 5'd2, 5'd1, 3'd0, 5'd20), a);
    issue(fop(5'd2, 5'd3, 5'd1, 3'd0, 5'd20), b);
    chk("waw_stall", b - a, 5);

    issue(fop(5'd0, 5'd2, 5'd1, 3'd0, 5'd9), a);
    issue(fma(7'b1000011, 5'd9, 5'd2, 5'd1, 3'd0, 5'd10), b);
    chk("fma_rs3_stall", b - a, 5);

    // FCLASS ignores its rs2 field and targets the integer file
    issue(fop(5'd0, 5'd2, 5'd1, 3'd0, 5'd21), a);
    issue(fop(5'd28, 5'd21, 5'd1, 3'd1, 5'd7), b);
    chk("fclass_no_rs2", b - a, 1);
    repeat (4) @(negedge CLK);
    chk("fclass_wb", {wb_en, wb_int, wb_rd}, 7'b1_1_00111);

    frm = 3'b001;
    issue(fop(5'd0, 5'd2, 5'd1, 3'd7, 5'd22), a);
    @(negedge CLK);
    chk("dyn_rm", {pipe_start, pipe_rm}, 4'b1_001);
    frm = 3'b101;
    issue(fop(5'd4, 5'd2, 5'd1, 3'd2, 5'd23), a);
    @(negedge CLK);
    chk("sgnj_rm", {pipe_start, pipe_rm}, 4'b1_010);
    issue(fop(5'd0, 5'd2, 5'd1, 3'd7, 5'd24), a);
    @(negedge CLK);
    chk("ill_dyn", {illegal, pipe_start, ds_start}, 3'b100);
    frm = 3'd0;

    w = fop(5'd0, 5'd2, 5'd1, 3'd0, 5'd24); w[26:25] = 2'b00; ill_q.push_back(w);
    ill_q.push_back(fop(5'd0, 5'd2, 5'd1, 3'd5, 5'd24));
    ill_q.push_back({12'h000, 5'd1, 3'b001, 5'd24, 7'b0000111});
`ifndef FPU_DIVSQRT_EN
    ill_q.push_back(fop(5'd11, 5'd0, 5'd1, 3'd0, 5'd27));
    ill_q.push_back(fop(5'd3, 5'd2, 5'd1, 3'd0, 5'd27));
`endif
    foreach (ill_q[i]) begin
      issue(ill_q[i], a);
      @(negedge CLK);
      chk("illegal_pulse", {illegal, pipe_start, ds_start}, 3'b100);
      @(negedge CLK);
      chk("illegal_once", illegal, 0);
    end

`ifdef FPU_DIVSQRT_EN
    frm = 3'b010;
    issue(fop(5'd3, 5'd2, 5'd1, 3'd7, 5'd6), a);
    @(negedge CLK);
    chk("ds_dyn", {ds_start, ds_sqrt, ds_rm}, 5'b1_0_010);
    frm = 3'd0;
    @(posedge CLK); #1;
    fork
      issue(fop(5'd3, 5'd2, 5'd1, 3'd0, 5'd11), b);
      ds_complete(3);
    join
    chk("div_stall", b - a, 7);
    ds_complete(1);

    // ds_done lands so the div result collides with the FADD writeback
    issue(fop(5'd3, 5'd2, 5'd1, 3'd0, 5'd12), a);
    issue(fop(5'd0, 5'd2, 5'd1, 3'd0, 5'd13), b);
    fork
      ds_complete(2);
      begin
        repeat (4) @(negedge CLK);
        chk("collide_pipe_first", {wb_en, wb_sel, wb_rd}, 7'b1_0_01101);
        @(negedge CLK);
        chk("collide_ds_next", {wb_en, wb_sel, ds_ack, wb_rd}, 8'b1_1_1_01100);
      end
    join

    issue(fop(5'd11, 5'd0, 5'd1, 3'd0, 5'd14), a);
    @(negedge CLK);
    chk("sqrt_start", {ds_start, ds_sqrt}, 2'b11);
    ds_complete(1);

    issue(fop(5'd3, 5'd2, 5'd1, 3'd0, 5'd25), a);
`endif
    issue(fop(5'd2, 5'd2, 5'd1, 3'd0, 5'd26), b);
    #2 nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge CLK);
      chk("post_reset_quiet", {wb_en, busy}, 2'b00);
    end

    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
